maincore_writeback: RTL
=======================

Name: maincore_writeback

Overview:
- Writeback stage for the main core. Collects results from the ALU path and the load/memory path, and buffers them in a small in-order queue.
- Drives the register-bank write port (rd index, rd value, writeback bank select, write strobe) one entry per cycle.
- Exports combinational read-after-write hazard flags to the operand-read stage, so it can stall on pending writes.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DATA_W, 32, result width.
- ADDR_W, 5, register index width.
- BANK_W, 5, bank-select width. Bits [1:0] select the bank: 00 GP, 01 SYS, 10 GBL, 11 invalid. Bit [2] selects the upper/lower half.

Ports:
- clk_in  in  1  core clock.
- reset_in  in  1  asynchronous, active-low reset.
- alu_valid_in  in  1  ALU result valid.
- alu_ready_out  out  1  ALU result accepted this cycle.
- alu_rd_in  in  ADDR_W  destination register.
- alu_bank_in  in  BANK_W  destination bank select.
- alu_val_in  in  DATA_W  result value.
- mem_valid_in  in  1  load result valid.
- mem_ready_out  out  1  load result accepted this cycle.
- mem_rd_in  in  ADDR_W  destination register.
- mem_bank_in  in  BANK_W  destination bank select.
- mem_val_in  in  DATA_W  load value.
- rd_out  out  ADDR_W  writeback register index.
- rd_val_out  out  DATA_W  writeback value.
- wb_bank_sel_out  out  BANK_W  writeback bank select.
- wb_out  out  1  write strobe; one register write per high cycle.
- rsa_in  in  ADDR_W  operand-A index from read stage.
- rsb_in  in  ADDR_W  operand-B index from read stage.
- bank_sel_in  in  BANK_W  read bank select.
- hazard_a_out  out  1  operand A has a pending write.
- hazard_b_out  out  1  operand B has a pending write.
- count_out  out  clog2(DEPTH)+1  queued entries, excluding the output register.
- bank_err_out  out  1  sticky: a bank-11 result was dropped.

Behaviour:
- Reset (reset_in low, asynchronous):
  - Queue empties; count_out = 0.
  - wb_out = 0; rd_out, rd_val_out and wb_bank_sel_out = 0.
  - bank_err_out = 0.
  - Reset mid-burst discards all queued and in-flight writes.
- Acceptance:
  - Ready outputs depend only on registered state (count) and the *_valid_in inputs, never on each other's ready.
  - At most one result is enqueued per cycle; mem has fixed priority.
  - mem_ready_out = (count < DEPTH).
  - alu_ready_out = (count < DEPTH) and not mem_valid_in.
  - A result is accepted on an edge where valid and ready are both high. A source must hold its valid and fields stable until accepted.
- Filtering at enqueue:
  - A result with bank[1:0]=00 and rd=0 is accepted and discarded; no queue slot is used and no write occurs.
  - A result with bank[1:0]=11 is accepted and discarded, and bank_err_out is set. bank_err_out is cleared only by reset.
- Drain:
  - On each edge with count > 0, the head entry is popped into the output register and wb_out goes high for the following cycle.
  - On an edge with count = 0, wb_out goes low.
  - The output register holds its last values while wb_out = 0.
- Latency: a result accepted on edge t drives wb_out = 1 during the cycle after edge t+1, provided the queue was empty.
- Throughput: one write per cycle, sustained.
- Simultaneous enqueue and dequeue: count is unchanged.
  - When full, ready stays low that cycle; there is no same-cycle pass-through.
- Order: writes are strictly in acceptance order. Pointers wrap modulo DEPTH.
- Hazard (combinational):
  - hazard_a_out = 1 if any valid queue entry, or the output register while wb_out = 1, has the same rd as rsa_in and the same bank[1:0] as bank_sel_in[1:0]. hazard_b_out is the same for rsb_in.
  - GP register 0 never flags.
  - bank_sel_in[1:0] = 11 never flags.
- The upper/lower bit is passed through unchanged and is not used in hazard matching.

Decomposition:
- Shared package (maincore_pkg): bank encodings BANK_GP=2'b00, BANK_SYS=2'b01, BANK_GBL=2'b10, BANK_INV=2'b11, plus the DATA_W/ADDR_W/BANK_W defaults. The register-file stage uses the same package.
- One sub-module, wb_fifo:
  - Parameterised by DEPTH and entry width; provides push, pop, full, empty and count.
  - Exposes a per-entry valid vector and a flattened entry array so the top level can build the hazard comparators.

Test Plan:
- Single ALU result (rd=5, bank=00, val=0xDEADBEEF) on an empty queue -> two cycles later wb_out=1 for exactly one cycle with rd_out=5, rd_val_out=0xDEADBEEF, wb_bank_sel_out=00; count returns to 0.
- alu_valid and mem_valid both high (alu rd=3, mem rd=4) -> mem accepted first, alu_ready_out=0 that cycle; writes appear as rd 4 then rd 3 on consecutive cycles.
- 6 back-to-back results with DEPTH=4 and the drain active -> count_out never exceeds 4, ready deasserts only when full, all 6 writes appear in order with no duplicates.
- Result with rd=0, bank=00, followed by one with bank=11 -> neither produces wb_out; bank_err_out rises after the second and stays high until reset.
- Queue holds SYS rd=7; read stage presents rsa=7 with bank 01, then bank 00 -> hazard_a_out=1, then 0; the flag clears on the cycle after wb_out for that entry drops.
- reset_in pulsed low with 3 entries queued -> wb_out, count_out and both hazard outputs go to 0 immediately; no writes appear after reset releases.

Source files
------------

// File: rtl/maincore_pkg.sv
// Shared definitions for the main-core register-bank stages (writeback, register file).
// Bank-select encodings and default datapath widths.
package maincore_pkg;

    typedef enum logic [1:0] {
        BANK_GP  = 2'b00,
        BANK_SYS = 2'b01,
        BANK_GBL = 2'b10,
        BANK_INV = 2'b11
    } bank_e;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_BANK_W = 5;

    // GP r0 is hard-wired, so writes to it are discarded and reads of it never stall.
    function automatic logic is_gp_zero(input logic [1:0] bank, input logic zero_rd);
        return (bank == BANK_GP) && zero_rd;
    endfunction

endpackage

// File: rtl/maincore_writeback_wb_fifo.sv
// In-order circular queue with a per-entry valid vector and flattened entry view.
// Latency: push visible at head one edge later; backpressure: caller must not push when full.
// Pop and push on the same edge leave count unchanged.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           valid,
    output logic [DEPTH*W-1:0]         entries
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        valid   = '0;
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - rd_ptr;
            valid[i] = ({1'b0, off} < count);
            entries[i*W +: W] = mem_q[i];
        end
    end

endmodule

// File: rtl/maincore_writeback.sv
// Writeback stage: arbitrates ALU/load results into an in-order queue and drives the register write port.
// Latency: accept on edge t, write strobe during the cycle after edge t+1; one write per cycle sustained.
// Backpressure: both ready outputs drop when the queue is full; mem has fixed priority over ALU.
module maincore_writeback
    import maincore_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BANK_W = DEFAULT_BANK_W
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     alu_valid_in,
    output logic                     alu_ready_out,
    input  logic [ADDR_W-1:0]        alu_rd_in,
    input  logic [BANK_W-1:0]        alu_bank_in,
    input  logic [DATA_W-1:0]        alu_val_in,
    input  logic                     mem_valid_in,
    output logic                     mem_ready_out,
    input  logic [ADDR_W-1:0]        mem_rd_in,
    input  logic [BANK_W-1:0]        mem_bank_in,
    input  logic [DATA_W-1:0]        mem_val_in,
    output logic [ADDR_W-1:0]        rd_out,
    output logic [DATA_W-1:0]        rd_val_out,
    output logic [BANK_W-1:0]        wb_bank_sel_out,
    output logic                     wb_out,
    input  logic [ADDR_W-1:0]        rsa_in,
    input  logic [ADDR_W-1:0]        rsb_in,
    input  logic [BANK_W-1:0]        bank_sel_in,
    output logic                     hazard_a_out,
    output logic                     hazard_b_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     bank_err_out
);

    localparam int EW = BANK_W + ADDR_W + DATA_W;
    localparam int RD_LSB = DATA_W;
    localparam int BK_LSB = DATA_W + ADDR_W;

    logic              q_full;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic [EW-1:0]     q_head;
    logic [DEPTH-1:0]  q_valid;
    logic [DEPTH*EW-1:0] q_entries;

    logic              mem_fire;
    logic              alu_fire;
    logic              take;
    logic [ADDR_W-1:0] sel_rd;
    logic [BANK_W-1:0] sel_bank;
    logic [DATA_W-1:0] sel_val;
    logic              drop_zero;
    logic              drop_inv;

    // Ready is a function of registered fullness and mem_valid only, never of the other ready.
    assign mem_ready_out = !q_full;
    assign alu_ready_out = !q_full && !mem_valid_in;

    assign mem_fire = mem_valid_in && mem_ready_out;
    assign alu_fire = alu_valid_in && alu_ready_out;
    assign take     = mem_fire || alu_fire;

    assign sel_rd   = mem_fire ? mem_rd_in   : alu_rd_in;
    assign sel_bank = mem_fire ? mem_bank_in : alu_bank_in;
    assign sel_val  = mem_fire ? mem_val_in  : alu_val_in;

    assign drop_zero = is_gp_zero(sel_bank[1:0], sel_rd == '0);
    assign drop_inv  = (sel_bank[1:0] == BANK_INV);
    assign q_push    = take && !drop_zero && !drop_inv;
    assign q_pop     = !q_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .push     (q_push),
        .push_dat ({sel_bank, sel_rd, sel_val}),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (count_out),
        .valid    (q_valid),
        .entries  (q_entries)
    );

    // Output register holds its last contents while the strobe is low.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wb_out          <= 1'b0;
            rd_out          <= '0;
            rd_val_out      <= '0;
            wb_bank_sel_out <= '0;
        end else begin
            wb_out <= q_pop;
            if (q_pop) begin
                wb_bank_sel_out <= q_head[BK_LSB +: BANK_W];
                rd_out          <= q_head[RD_LSB +: ADDR_W];
                rd_val_out      <= q_head[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)
            bank_err_out <= 1'b0;
        else if (take && drop_inv)
            bank_err_out <= 1'b1;
    end

    logic hit_a;
    logic hit_b;
    logic look_ok;

    // Matching ignores the upper/lower half bit; only the bank and index select a register.
    always_comb begin
        hit_a = wb_out && (rd_out == rsa_in) && (wb_bank_sel_out[1:0] == bank_sel_in[1:0]);
        hit_b = wb_out && (rd_out == rsb_in) && (wb_bank_sel_out[1:0] == bank_sel_in[1:0]);
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_entries[i*EW+BK_LSB +: 2] == bank_sel_in[1:0])) begin
                if (q_entries[i*EW+RD_LSB +: ADDR_W] == rsa_in) hit_a = 1'b1;
                if (q_entries[i*EW+RD_LSB +: ADDR_W] == rsb_in) hit_b = 1'b1;
            end
        end
    end

    assign look_ok      = (bank_sel_in[1:0] != BANK_INV);
    assign hazard_a_out = look_ok && !is_gp_zero(bank_sel_in[1:0], rsa_in == '0) && hit_a;
    assign hazard_b_out = look_ok && !is_gp_zero(bank_sel_in[1:0], rsb_in == '0) && hit_b;

    logic unused_bank_bits;
    assign unused_bank_bits = &{1'b0, bank_sel_in[BANK_W-1:2]};

endmodule
